// File: rtl/pa_bitonic_sort_seq.sv
// Sequential bitonic sorter: loads one frame serially, applies one network
// column per clock through NUM_ELEM/2 compare/swap cells, then drains serially.

module pa_cmp_swap #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         mode_i,
  output logic [W-1:0] lo_o,
  output logic [W-1:0] hi_o
);
  logic a_gt_b;
  assign a_gt_b = (a_i > b_i);

  // mode_i=1 reverses the direction of this pair
  always_comb begin
    if (a_gt_b ^ mode_i) begin
      lo_o = b_i;
      hi_o = a_i;
    end else begin
      lo_o = a_i;
      hi_o = b_i;
    end
  end
endmodule

module pa_bitonic_sort_seq #(
  parameter int SIZE_DATA = 8,
  parameter int NUM_ELEM  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic                 i_order,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_last,
  output logic                 o_busy
);
  localparam int LOG2_N    = $clog2(NUM_ELEM);
  localparam int NUM_STEPS = LOG2_N * (LOG2_N + 1) / 2;
  localparam int IDX_W     = LOG2_N;
  localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int NUM_PAIRS = NUM_ELEM / 2;

  typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_DRAIN} state_t;

  // Map a step index onto log2(k) (sel=1) or log2(j) (sel=0) of the (k,j) sequence.
  function automatic int step_log(input int s, input bit sel_k);
    int c;
    int r;
    c = 0;
    r = 0;
    for (int p = 1; p <= LOG2_N; p++) begin
      for (int q = p - 1; q >= 0; q--) begin
        if (c == s) r = sel_k ? p : q;
        c++;
      end
    end
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
  logic                 order_q, order_d;
  logic [SIZE_DATA-1:0] buf_q [NUM_ELEM];
  logic [SIZE_DATA-1:0] buf_d [NUM_ELEM];

  logic [LOG2_N:0]      k_tab [NUM_STEPS];
  logic [IDX_W-1:0]     j_tab [NUM_STEPS];
  logic [LOG2_N:0]      k_sel;
  logic [IDX_W-1:0]     j_sel;
  logic [IDX_W-1:0]     low_mask;

  logic [IDX_W-1:0]     pair_lo   [NUM_PAIRS];
  logic [IDX_W-1:0]     pair_hi   [NUM_PAIRS];
  logic [SIZE_DATA-1:0] cell_a    [NUM_PAIRS];
  logic [SIZE_DATA-1:0] cell_b    [NUM_PAIRS];
  logic                 cell_mode [NUM_PAIRS];
  logic [SIZE_DATA-1:0] cell_lo   [NUM_PAIRS];
  logic [SIZE_DATA-1:0] cell_hi   [NUM_PAIRS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STEPS; gi++) begin : g_tab
      assign k_tab[gi] = (LOG2_N + 1)'(1) << step_log(gi, 1'b1);
      assign j_tab[gi] = IDX_W'(1) << step_log(gi, 1'b0);
    end
    for (gi = 0; gi < NUM_PAIRS; gi++) begin : g_cell
      pa_cmp_swap #(.W(SIZE_DATA)) u_cs (
        .a_i   (cell_a[gi]),
        .b_i   (cell_b[gi]),
        .mode_i(cell_mode[gi]),
        .lo_o  (cell_lo[gi]),
        .hi_o  (cell_hi[gi])
      );
    end
  endgenerate

  assign k_sel    = k_tab[step_cnt_q];
  assign j_sel    = j_tab[step_cnt_q];
  assign low_mask = j_sel - IDX_W'(1);

  // Pair m's lower index is m with a zero inserted at bit position log2(j).
  always_comb begin
    for (int m = 0; m < NUM_PAIRS; m++) begin
      pair_lo[m]   = ((IDX_W'(m) & ~low_mask) << 1) | (IDX_W'(m) & low_mask);
      pair_hi[m]   = pair_lo[m] | j_sel;
      cell_a[m]    = buf_q[pair_lo[m]];
      cell_b[m]    = buf_q[pair_hi[m]];
      cell_mode[m] = (|({1'b0, pair_lo[m]} & k_sel)) ^ order_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    drain_cnt_d = drain_cnt_q;
    step_cnt_d  = step_cnt_q;
    order_d     = order_q;
    buf_d       = buf_q;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    o_data      = '0;
    o_last      = 1'b0;
    o_busy      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        o_ready = 1'b1;
        if (i_valid) begin
          buf_d[load_cnt_q] = i_data;
          if (load_cnt_q == '0) order_d = i_order;
          if (load_cnt_q == IDX_W'(NUM_ELEM - 1)) begin
            load_cnt_d = '0;
            state_d    = ST_SORT;
          end else begin
            load_cnt_d = load_cnt_q + IDX_W'(1);
          end
        end
      end
      ST_SORT: begin
        o_busy = 1'b1;
        for (int m = 0; m < NUM_PAIRS; m++) begin
          buf_d[pair_lo[m]] = cell_lo[m];
          buf_d[pair_hi[m]] = cell_hi[m];
        end
        if (step_cnt_q == STEP_W'(NUM_STEPS - 1)) begin
          step_cnt_d = '0;
          state_d    = ST_DRAIN;
        end else begin
          step_cnt_d = step_cnt_q + STEP_W'(1);
        end
      end
      ST_DRAIN: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        o_data  = buf_q[drain_cnt_q];
        o_last  = (drain_cnt_q == IDX_W'(NUM_ELEM - 1));
        if (i_ready) begin
          if (o_last) begin
            drain_cnt_d = '0;
            state_d     = ST_LOAD;
          end else begin
            drain_cnt_d = drain_cnt_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_LOAD;
      load_cnt_q  <= '0;
      drain_cnt_q <= '0;
      step_cnt_q  <= '0;
      order_q     <= 1'b0;
      for (int e = 0; e < NUM_ELEM; e++) buf_q[e] <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      step_cnt_q  <= step_cnt_d;
      order_q     <= order_d;
      buf_q       <= buf_d;
    end
  end
endmodule

// File: tb/tb_pa_bitonic_sort_seq.sv
// Scoreboard bench for pa_bitonic_sort_seq: expected sorted frames are queued
// at load time and compared against each output handshake.

module tb_pa_bitonic_sort_seq;
  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_data;
  logic       i_order;
  logic       o_valid;
  logic       i_ready = 1'b1;
  logic [7:0] o_data;
  logic       o_last;
  logic       o_busy;

  pa_bitonic_sort_seq #(.SIZE_DATA(8), .NUM_ELEM(8)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .i_order(i_order),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (o_data),
    .o_last (o_last),
    .o_busy (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_accept = 0;
  int out_total = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_word;
  bit bp_en = 1'b0;
  int bp_idx = 0;
  logic [5:0] bp_pat = 6'b101001;
  logic prev_valid = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic prev_last = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Downstream ready: 1,0,0,1,0,1 repeating when backpressure is enabled
  always @(posedge i_clk) begin
    #1;
    if (bp_en) begin
      i_ready = bp_pat[bp_idx];
      bp_idx  = (bp_idx == 5) ? 0 : bp_idx + 1;
    end else begin
      i_ready = 1'b1;
    end
  end

  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (o_valid) begin
        check_val("ready_low_drain", o_ready, 0);
        if (!prev_valid) check_val("latency", cyc - last_accept, 6);
        if (prev_stall) begin
          check_val("stall_data", o_data, prev_data);
          check_val("stall_last", o_last, prev_last);
        end
        if (i_ready) begin
          if (exp_q.size() == 0) begin
            check_val("unexpected_word", 1, 0);
          end else begin
            exp_word = exp_q.pop_front();
            check_val("data", o_data, exp_word[7:0]);
            check_val("last", o_last, exp_word[8]);
          end
          out_total++;
          $display("out word %0d: data=%0d last=%0d", out_total, o_data, o_last);
        end
      end
      prev_valid = o_valid;
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_last  = o_last;
    end
  end

  task automatic send_frame(input logic [7:0] d[8], input logic ord, input bit bubbles,
                            input bit push, output int first_acc);
    logic [7:0] s[8];
    logic [7:0] t;
    int guard;
    s = d;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 7 - a; b++)
        if (ord ? (s[b] < s[b+1]) : (s[b] > s[b+1])) begin
          t = s[b]; s[b] = s[b+1]; s[b+1] = t;
        end
    if (push) for (int w = 0; w < 8; w++) exp_q.push_back({(w == 7), s[w]});
    first_acc = 0;
    for (int w = 0; w < 8; w++) begin
      if (bubbles && ($urandom_range(0, 1) == 1)) begin
        i_valid = 1'b0;
        @(posedge i_clk); #1;
      end
      i_valid = 1'b1;
      i_data  = d[w];
      i_order = ord ^ w[0];
      guard   = 0;
      @(negedge i_clk);
      while (!o_ready && guard < 100) begin
        @(negedge i_clk);
        guard++;
      end
      if (guard >= 100) check_val("accept_timeout", 0, 1);
      @(posedge i_clk); #1;
      if (w == 0) first_acc = cyc;
      if (w == 7) last_accept = cyc;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge i_clk);
      g++;
    end while ((exp_q.size() != 0 || o_busy) && g < 500);
    if (g >= 500) check_val("idle_timeout", 0, 1);
    @(posedge i_clk); #1;
  endtask

  logic [7:0] f[8];
  int fa1, fa2, fa_dummy;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_order = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check_val("rst_ready", o_ready, 1);
    check_val("rst_valid", o_valid, 0);
    check_val("rst_data", o_data, 0);
    check_val("rst_last", o_last, 0);
    check_val("rst_busy", o_busy, 0);
    @(negedge i_clk) i_rst = 1'b0;
    @(posedge i_clk); #1;

    f = '{5, 3, 7, 1, 8, 2, 6, 4};
    send_frame(f, 1'b0, 1'b0, 1'b1, fa_dummy);
    i_valid = 1'b0;
    @(negedge i_clk);
    check_val("sort_ready", o_ready, 0);
    check_val("sort_busy", o_busy, 1);
    check_val("sort_valid", o_valid, 0);
    wait_idle();

    send_frame(f, 1'b1, 1'b0, 1'b1, fa_dummy);
    i_valid = 1'b0;
    wait_idle();

    f = '{255, 0, 255, 0, 128, 128, 0, 255};
    send_frame(f, 1'b0, 1'b0, 1'b1, fa_dummy);
    i_valid = 1'b0;
    wait_idle();

    bp_en = 1'b1;
    f = '{5, 3, 7, 1, 8, 2, 6, 4};
    send_frame(f, 1'b0, 1'b1, 1'b1, fa_dummy);
    i_valid = 1'b0;
    wait_idle();
    bp_en = 1'b0;

    send_frame(f, 1'b0, 1'b0, 1'b0, fa_dummy);
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check_val("midrst_valid", o_valid, 0);
    check_val("midrst_busy", o_busy, 0);
    check_val("midrst_ready", o_ready, 1);
    @(negedge i_clk) i_rst = 1'b0;
    @(posedge i_clk); #1;
    f = '{9, 9, 1, 0, 3, 2, 7, 6};
    send_frame(f, 1'b0, 1'b0, 1'b1, fa_dummy);
    i_valid = 1'b0;
    wait_idle();

    f = '{200, 17, 33, 4, 99, 250, 1, 64};
    send_frame(f, 1'b0, 1'b0, 1'b1, fa1);
    f = '{8, 7, 6, 5, 4, 3, 2, 1};
    send_frame(f, 1'b0, 1'b0, 1'b1, fa2);
    i_valid = 1'b0;
    check_val("frame_period", fa2 - fa1, 22);
    wait_idle();

    check_val("total_words", out_total, 56);
    check_val("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
